usart_tx_arbiter: RTL and testbench

//  Shares the single USART byte transmitter (USART_Send) between NUM_REQ frame sources
//  (measurement frames, status/heartbeat frames). Sits between the sources and the transmitter.

---
 rtl/ball_screw_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/usart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_usart_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_screw_pkg.sv
// Shared types and defaults for the USART transmit arbiter.
// USART_ARB_CHECKSUM_EN adds the CKSUM state to the FSM encoding.
package ball_screw_pkg;

    localparam int ARB_DATA_W      = 8;
    localparam int ARB_GAP_CYC     = 500;
    localparam int ARB_TIMEOUT_CYC = 5_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_LOAD,
        ST_WAIT,
`ifdef USART_ARB_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_GAP
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // Walk offsets high to low so the smallest offset from ptr wins last.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = IW'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usart_tx_arbiter.sv
// Round-robin frame arbiter in front of the single USART byte transmitter.
// Define USART_ARB_CHECKSUM_EN to append an XOR checksum byte to every frame.
module usart_tx_arbiter
    import ball_screw_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int GAP_CYC     = ARB_GAP_CYC,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC,
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      CLOCK_50M,
    input  logic                      RST_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_first,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      Frame_Start_Sig,
    output logic                      Data_Send_Sig,
    output logic [DATA_W-1:0]         Data,
    input  logic                      Tx_Done,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    output logic                      err_pulse
);

    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    arb_state_t          state, nstate;
    logic [IW-1:0]       ptr, win_idx;
    logic                win_any, last_q, ds_q, armed;
    logic [CW-1:0]       cnt;
    logic [NUM_REQ-1:0]  cand, drop_req, drop_sel;
    logic                timeout, gap_end, load_hit;
`ifdef USART_ARB_CHECKSUM_EN
    logic [DATA_W-1:0]   cks;
`endif

    assign cand     = req_valid & req_first;
    assign drop_req = req_valid & ~req_first;
    assign drop_sel = drop_req & (~drop_req + NUM_REQ'(1));
    assign timeout  = (cnt == CW'(TIMEOUT_CYC - 1));
    assign gap_end  = (cnt == CW'(GAP_CYC - 1));
    assign load_hit = (state == ST_LOAD) && req_valid[grant_id];

    assign Frame_Start_Sig = (state == ST_START);
    assign Data_Send_Sig   = ds_q;
    assign busy            = (state != ST_IDLE);

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req     (cand),
        .ptr     (ptr),
        .gnt_idx (win_idx),
        .gnt_any (win_any)
    );

    always_comb begin
        nstate    = state;
        req_ready = '0;
        err_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                // armed keeps req_ready low while RST_n is held
                if (armed && |drop_req) begin
                    req_ready = drop_sel;
                    err_pulse = 1'b1;
                end
                if (win_any) nstate = ST_START;
            end
            ST_START: nstate = ST_LOAD;
            ST_LOAD: begin
                if (req_valid[grant_id]) begin
                    req_ready[grant_id] = 1'b1;
                    nstate              = ST_WAIT;
                end else if (timeout) begin
                    err_pulse = 1'b1;
                    nstate    = ST_GAP;
                end
            end
            ST_WAIT: begin
                if (Tx_Done) begin
`ifdef USART_ARB_CHECKSUM_EN
                    nstate = last_q ? ST_CKSUM : ST_LOAD;
`else
                    nstate = last_q ? ST_GAP : ST_LOAD;
`endif
                end else if (timeout) begin
                    err_pulse = 1'b1;
                    nstate    = ST_GAP;
                end
            end
`ifdef USART_ARB_CHECKSUM_EN
            ST_CKSUM: begin
                if (Tx_Done) begin
                    nstate = ST_GAP;
                end else if (timeout) begin
                    err_pulse = 1'b1;
                    nstate    = ST_GAP;
                end
            end
`endif
            ST_GAP: if (gap_end) nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            grant_id <= '0;
            last_q   <= 1'b0;
            ds_q     <= 1'b0;
            Data     <= '0;
            cnt      <= '0;
            armed    <= 1'b0;
`ifdef USART_ARB_CHECKSUM_EN
            cks      <= '0;
`endif
        end else begin
            state <= nstate;
            armed <= 1'b1;
            ds_q  <= 1'b0;
            // One counter serves LOAD/WAIT/CKSUM timeouts and the GAP count.
            if (nstate != state)      cnt <= '0;
            else if (state != ST_IDLE) cnt <= cnt + 1'b1;
            if (state == ST_IDLE && win_any) grant_id <= win_idx;
            if (load_hit) begin
                Data   <= req_data[int'(grant_id)*DATA_W +: DATA_W];
                ds_q   <= 1'b1;
                last_q <= req_last[grant_id];
            end
            if (state == ST_GAP && gap_end)
                ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
`ifdef USART_ARB_CHECKSUM_EN
            if (state == ST_START) cks <= '0;
            else if (load_hit) cks <= cks ^ req_data[int'(grant_id)*DATA_W +: DATA_W];
            if (state == ST_WAIT && nstate == ST_CKSUM) begin
                Data <= cks;
                ds_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Self-checking bench for usart_tx_arbiter: vector table of frames plus corner sequences.
`timescale 1ns/1ps
module tb_usart_tx_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 8;
    localparam int GAP = 20;
    localparam int TO  = 100;
`ifdef USART_ARB_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic [NR-1:0]    req_valid, req_first, req_last, req_ready;
    logic [NR*DW-1:0] req_data;
    logic             fs, ds, tx_done, busy, err;
    logic [DW-1:0]    data;
    logic [0:0]       grant_id;

    usart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .CLOCK_50M       (clk),
        .RST_n           (rst_n),
        .req_valid       (req_valid),
        .req_first       (req_first),
        .req_last        (req_last),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .Frame_Start_Sig (fs),
        .Data_Send_Sig   (ds),
        .Data            (data),
        .Tx_Done         (tx_done),
        .grant_id        (grant_id),
        .busy            (busy),
        .err_pulse       (err)
    );

    typedef struct packed { logic first; logic last; logic [7:0] d; } beat_t;
    typedef struct { int lane; int n; logic [31:0] b; logic [7:0] cks; } vec_t;

    beat_t      lane_q [NR][$];
    logic [7:0] exp_q[$];
    int         gnt_q[$];
    int         err_cycs[$];
    int errors = 0, checks = 0;
    int cyc = 0, ds_cnt = 0, fs_cnt = 0, err_cnt = 0;
    int done_cyc = 0, idle_cyc = 0, ds_cyc = 0;
    bit tx_mute = 1'b0, busy_prev = 1'b0;
    logic [NR-1:0] rdy_s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit lanes_empty();
        for (int i = 0; i < NR; i++) if (lane_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] xor_of(input int n, input logic [31:0] b);
        logic [7:0] x = 8'h00;
        for (int k = 0; k < n; k++) x ^= b[31-8*k -: 8];
        return x;
    endfunction

    task automatic drive_lanes();
        for (int i = 0; i < NR; i++) begin
            if (lane_q[i].size() != 0) begin
                req_valid[i]         = 1'b1;
                req_first[i]         = lane_q[i][0].first;
                req_last[i]          = lane_q[i][0].last;
                req_data[i*DW +: DW] = lane_q[i][0].d;
            end else begin
                req_valid[i]         = 1'b0;
                req_first[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic put_frame(input int lane, input int n, input logic [31:0] b, input bit term);
        beat_t bt;
        for (int k = 0; k < n; k++) begin
            bt.first = (k == 0);
            bt.last  = term && (k == n - 1);
            bt.d     = b[31-8*k -: 8];
            lane_q[lane].push_back(bt);
        end
    endtask

    // Expected bytes in transmit order; checksum byte only for completed frames.
    task automatic exp_frame(input int lane, input int n, input logic [31:0] b,
                             input bit full, input logic [7:0] cks);
        gnt_q.push_back(lane);
        for (int k = 0; k < n; k++) exp_q.push_back(b[31-8*k -: 8]);
        if (full && CK == 1) exp_q.push_back(cks);
    endtask

    task automatic flush_all();
        for (int i = 0; i < NR; i++) lane_q[i].delete();
        exp_q.delete();
        gnt_q.delete();
        drive_lanes();
    endtask

    task automatic settle(input string name, input int budget);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (!(busy == 1'b0 && exp_q.size() == 0 && lanes_empty()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_settle"}, 32'(n < budget), 1);
        if (n >= budget) flush_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requester models: a byte leaves its lane on the edge where req_ready was high.
    initial begin
        drive_lanes();
        forever begin
            @(negedge clk);
            rdy_s = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++)
                if (rdy_s[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
            drive_lanes();
        end
    end

    // Transmitter model: Tx_Done 10 cycles after each Data_Send_Sig.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ds && !tx_mute && rst_n) begin
                repeat (10) @(posedge clk);
                #1;
                tx_done  = 1'b1;
                done_cyc = cyc;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    // Output monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ds) begin
                    ds_cnt++;
                    ds_cyc = cyc;
                    if (exp_q.size() == 0) chk("byte_pending", 0, 1);
                    else chk("tx_byte", 32'(data), 32'(exp_q.pop_front()));
                end
                if (fs) begin
                    fs_cnt++;
                    if (gnt_q.size() == 0) chk("grant_pending", 0, 1);
                    else chk("grant_id", 32'(grant_id), gnt_q.pop_front());
                end
                if (err) begin
                    err_cnt++;
                    err_cycs.push_back(cyc);
                end
                if (req_ready != '0) chk("ready_onehot", 32'($onehot(req_ready)), 1);
                if (busy_prev && !busy) idle_cyc = cyc;
                busy_prev = busy;
            end else begin
                busy_prev = 1'b0;
            end
        end
    end

    initial begin
        vec_t vt[4];
        int   fs0, ds0, er0, n;

        vt[0] = '{0, 3, 32'hA5_01_02_00, 8'hA6};
        vt[1] = '{1, 2, 32'h12_34_00_00, 8'h26};
        vt[2] = '{0, 1, 32'h7E_00_00_00, 8'h7E};
        vt[3] = '{1, 4, 32'hFF_00_55_AA, 8'h00};

        #5;
        chk("reset_outputs", {16'h0, busy, fs, ds, err, req_ready, grant_id, data}, 0);
        do_reset();
        @(negedge clk);
        chk("post_reset_idle", {busy, fs, ds, err, req_ready}, 0);

        // Single frames, each followed by the full inter-frame gap.
        for (int v = 0; v < 4; v++) begin
            fs0 = fs_cnt; ds0 = ds_cnt; er0 = err_cnt;
            put_frame(vt[v].lane, vt[v].n, vt[v].b, 1'b1);
            exp_frame(vt[v].lane, vt[v].n, vt[v].b, 1'b1, vt[v].cks);
            settle($sformatf("vec%0d", v), 2000);
            chk($sformatf("vec%0d_starts", v), fs_cnt - fs0, 1);
            chk($sformatf("vec%0d_sends", v), ds_cnt - ds0, vt[v].n + CK);
            chk($sformatf("vec%0d_errs", v), err_cnt - er0, 0);
            chk($sformatf("vec%0d_gap", v), idle_cyc - done_cyc, GAP + 1);
        end

        // Contention right after reset: req0 first, then req1, then req0 again.
        do_reset();
        fs0 = fs_cnt;
        put_frame(0, 2, 32'h11_12_00_00, 1'b1);
        put_frame(1, 1, 32'h21_00_00_00, 1'b1);
        exp_frame(0, 2, 32'h11_12_00_00, 1'b1, xor_of(2, 32'h11_12_00_00));
        exp_frame(1, 1, 32'h21_00_00_00, 1'b1, xor_of(1, 32'h21_00_00_00));
        settle("contend1", 3000);
        put_frame(0, 1, 32'h13_00_00_00, 1'b1);
        put_frame(1, 1, 32'h22_00_00_00, 1'b1);
        exp_frame(0, 1, 32'h13_00_00_00, 1'b1, xor_of(1, 32'h13_00_00_00));
        exp_frame(1, 1, 32'h22_00_00_00, 1'b1, xor_of(1, 32'h22_00_00_00));
        settle("contend2", 3000);
        chk("contend_starts", fs_cnt - fs0, 4);

        // Req1 stalls after its first byte: LOAD timeout, pointer moves on to req0.
        fs0 = fs_cnt; ds0 = ds_cnt; er0 = err_cnt;
        put_frame(1, 1, 32'h5A_00_00_00, 1'b0);
        exp_frame(1, 1, 32'h5A_00_00_00, 1'b0, 8'h00);
        settle("stall", 2000);
        chk("stall_errs", err_cnt - er0, 1);
        chk("stall_sends", ds_cnt - ds0, 1);
        put_frame(0, 2, 32'hC0_C1_00_00, 1'b1);
        put_frame(1, 1, 32'hD0_00_00_00, 1'b1);
        exp_frame(0, 2, 32'hC0_C1_00_00, 1'b1, xor_of(2, 32'hC0_C1_00_00));
        exp_frame(1, 1, 32'hD0_00_00_00, 1'b1, xor_of(1, 32'hD0_00_00_00));
        settle("after_stall", 3000);
        chk("after_stall_starts", fs_cnt - fs0, 3);

        // Tx_Done never comes: WAIT aborts after TO cycles; leftover byte is then dropped.
        tx_mute = 1'b1;
        ds0 = ds_cnt; er0 = err_cnt;
        err_cycs.delete();
        put_frame(0, 2, 32'hE0_E1_00_00, 1'b1);
        exp_frame(0, 2, 32'hE0_00_00_00, 1'b0, 8'h00);
        exp_q.delete();
        exp_q.push_back(8'hE0);
        settle("no_done", 2000);
        tx_mute = 1'b0;
        chk("no_done_sends", ds_cnt - ds0, 1);
        chk("no_done_errs", err_cnt - er0, 2);
        if (err_cycs.size() == 0) chk("no_done_err_seen", 0, 1);
        else chk("no_done_abort_time", err_cycs[0] - ds_cyc, TO - 1);

        // Stray byte without first in IDLE: consumed and flagged, nothing sent.
        fs0 = fs_cnt; ds0 = ds_cnt; er0 = err_cnt;
        lane_q[1].push_back(beat_t'{first: 1'b0, last: 1'b0, d: 8'h99});
        settle("drop", 200);
        chk("drop_errs", err_cnt - er0, 1);
        chk("drop_quiet", (fs_cnt - fs0) + (ds_cnt - ds0), 0);

        // Reset while waiting for Tx_Done, then the frame is resent from its start.
        put_frame(0, 3, 32'h31_32_33_00, 1'b1);
        exp_frame(0, 3, 32'h31_32_33_00, 1'b1, xor_of(3, 32'h31_32_33_00));
        ds0 = ds_cnt;
        n = 0;
        while (ds_cnt < ds0 + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_frame_reached", 32'(n < 500), 1);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {16'h0, busy, fs, ds, err, req_ready, grant_id, data}, 0);
        flush_all();
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fs0 = fs_cnt; ds0 = ds_cnt;
        put_frame(0, 3, 32'h31_32_33_00, 1'b1);
        exp_frame(0, 3, 32'h31_32_33_00, 1'b1, xor_of(3, 32'h31_32_33_00));
        settle("resend", 2000);
        chk("resend_starts", fs_cnt - fs0, 1);
        chk("resend_sends", ds_cnt - ds0, 3 + CK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
